// File: rtl/reversi_accel_mul_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reversi_accel_mul_arbiter_pkg
//  Purpose  : Shared constants and types for the shared-multiplier arbiter
//             slice of the reversi accelerator datapath.
//  Contents : MUL_A_W / MUL_P_W  operand and product widths
//             LATENCY            cycles through the multiplier wrapper
//             req_id_t           requester index type for the default config
//  Revision : 1.0  initial release
// ============================================================================
package reversi_accel_mul_arbiter_pkg;

    localparam int MUL_A_W     = 16;
    localparam int MUL_P_W     = 32;
    // Input register stage plus product register stage.
    localparam int LATENCY     = 2;

    localparam int NUM_REQ_DEF = 4;
    localparam int ID_W_DEF    = 2;

    typedef logic [ID_W_DEF-1:0] req_id_t;

endpackage
`default_nettype wire

// File: rtl/reversi_accel_mul.sv
`default_nettype none
// ============================================================================
//  Module   : reversi_accel_mul
//  Purpose  : Pipelined unsigned 16x16->32 multiplier with a global clock
//             enable. Operands are registered, then the product passes
//             through LATENCY-1 product registers. Datapath only, no reset.
//  Ports    : clk        clock
//             ce         pipeline advance enable
//             din0/din1  operands (16 bits each)
//             dout       product (32 bits)
//  Revision : 1.0  initial release
// ============================================================================
module reversi_accel_mul #(
    parameter int LATENCY = 2
) (
    input  logic                                               clk,
    input  logic                                               ce,
    input  logic [reversi_accel_mul_arbiter_pkg::MUL_A_W-1:0] din0,
    input  logic [reversi_accel_mul_arbiter_pkg::MUL_A_W-1:0] din1,
    output logic [reversi_accel_mul_arbiter_pkg::MUL_P_W-1:0] dout
);

    import reversi_accel_mul_arbiter_pkg::*;

    logic [MUL_A_W-1:0] a_q, a_d;
    logic [MUL_A_W-1:0] b_q, b_d;
    logic [MUL_P_W-1:0] p_q [LATENCY-1];
    logic [MUL_P_W-1:0] p_d [LATENCY-1];

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        p_d = p_q;
        if (ce) begin
            a_d    = din0;
            b_d    = din1;
            p_d[0] = MUL_P_W'(a_q) * MUL_P_W'(b_q);
            for (int k = 1; k < LATENCY - 1; k++) begin
                p_d[k] = p_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
        p_q <= p_d;
    end

    assign dout = p_q[LATENCY-2];

endmodule
`default_nettype wire

// File: rtl/reversi_accel_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : reversi_accel_rr_arbiter
//  Purpose  : Combinational round-robin grant with a registered priority
//             pointer. The pointer only advances on a grant, so a disabled
//             (stalled) cycle never disturbs the rotation.
//  Ports    : clk, reset        clock / synchronous active-high reset
//             req[NUM_REQ]      request vector
//             en                grant enable
//             grant[NUM_REQ]    one-hot grant (zero when en=0)
//             grant_id[ID_W]    index of the granted requester
//             grant_any         a grant was issued this cycle
//  Revision : 1.0  initial release
// ============================================================================
module reversi_accel_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_any
);

    import reversi_accel_mul_arbiter_pkg::*;

    // One extra bit so pointer+offset cannot overflow before the wrap.
    localparam int SUM_W = ID_W + 1;

    logic [ID_W-1:0]  ptr_q;
    logic [ID_W-1:0]  ptr_d;
    logic [SUM_W-1:0] w_sum;
    logic [ID_W-1:0]  w_idx;

    // Scan from the pointer upward with wrap-around; first hit wins.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        w_sum     = '0;
        w_idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, ptr_q} + SUM_W'(k);
            if (w_sum >= SUM_W'(NUM_REQ)) begin
                w_sum = w_sum - SUM_W'(NUM_REQ);
            end
            w_idx = w_sum[ID_W-1:0];
            if (en && !grant_any && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                grant_id     = w_idx;
                grant_any    = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/reversi_accel_mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : reversi_accel_mul_arbiter
//  Purpose  : Shares one pipelined multiplier among NUM_REQ requesters.
//             Round-robin issue of at most one operand pair per cycle; the
//             requester ID travels alongside in a valid/ID shift register
//             that advances on the same ce as the multiplier.
//  Ports    : clk, reset           clock / synchronous active-high reset
//             req_valid/req_ready  per-requester handshake
//             req_a/req_b          packed 16-bit operands, requester i at [16i+:16]
//             res_valid/res_ready  result handshake
//             res_id, res_data     owner index and 32-bit product
//             busy                 any operation in flight
//  Revision : 1.0  initial release
// ============================================================================
module reversi_accel_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int LATENCY = reversi_accel_mul_arbiter_pkg::LATENCY
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [16*NUM_REQ-1:0]  req_a,
    input  logic [16*NUM_REQ-1:0]  req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ID_W-1:0]        res_id,
    output logic [31:0]            res_data,
    output logic                   busy
);

    import reversi_accel_mul_arbiter_pkg::*;

    logic                 w_ce;
    logic                 w_en;
    logic [NUM_REQ-1:0]   w_grant;
    logic [ID_W-1:0]      w_grant_id;
    logic                 w_grant_any;
    logic [MUL_A_W-1:0]   w_din0;
    logic [MUL_A_W-1:0]   w_din1;

    logic [LATENCY-1:0]   vld_q, vld_d;
    logic [ID_W-1:0]      id_q [LATENCY];
    logic [ID_W-1:0]      id_d [LATENCY];

    // A held result freezes everything upstream, multiplier included.
    assign w_ce = !(vld_q[LATENCY-1] && !res_ready);
    // No grants during reset: whatever is issued would be discarded anyway.
    assign w_en = w_ce && !reset;

    reversi_accel_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (req_valid),
        .en        (w_en),
        .grant     (w_grant),
        .grant_id  (w_grant_id),
        .grant_any (w_grant_any)
    );

    assign req_ready = w_grant;

    // One-hot operand mux; operands are don't-care on a bubble.
    always_comb begin
        w_din0 = '0;
        w_din1 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_din0 = req_a[i*MUL_A_W +: MUL_A_W];
                w_din1 = req_b[i*MUL_A_W +: MUL_A_W];
            end
        end
    end

    reversi_accel_mul #(
        .LATENCY (LATENCY)
    ) u_mul (
        .clk  (clk),
        .ce   (w_ce),
        .din0 (w_din0),
        .din1 (w_din1),
        .dout (res_data)
    );

    // Valid/ID tracker, advanced on exactly the same ce as the multiplier.
    always_comb begin
        vld_d = vld_q;
        id_d  = id_q;
        if (w_ce) begin
            vld_d[0] = w_grant_any;
            id_d[0]  = w_grant_id;
            for (int k = 1; k < LATENCY; k++) begin
                vld_d[k] = vld_q[k-1];
                id_d[k]  = id_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                id_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            id_q  <= id_d;
        end
    end

    assign res_valid = vld_q[LATENCY-1];
    assign res_id    = id_q[LATENCY-1];
    assign busy      = |vld_q;

endmodule
`default_nettype wire
